// File: rtl/fifo_csr_ctrl.sv
// CSR subordinate and flush/drain sequencer for the async data FIFO, all in the csr_clk domain.
// Optional interrupt output and IRQ_EN register are enabled by defining FIFO_CSR_IRQ_EN.
module fifo_csr_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic                  i_csr_clk,
  input  logic                  i_csr_resetn,
  input  logic [ADDR_WIDTH-1:0] i_csr_awaddr,
  input  logic                  i_csr_awvalid,
  output logic                  o_csr_awready,
  input  logic [DATA_WIDTH-1:0] i_csr_wdata,
  input  logic                  i_csr_wvalid,
  output logic                  o_csr_wready,
  output logic                  o_csr_bvalid,
  input  logic                  i_csr_bready,
  output logic [1:0]            o_csr_bresp,
  input  logic [ADDR_WIDTH-1:0] i_csr_araddr,
  input  logic                  i_csr_arvalid,
  output logic                  o_csr_arready,
  output logic [DATA_WIDTH-1:0] o_csr_rdata,
  output logic                  o_csr_rvalid,
  input  logic                  i_csr_rready,
  output logic [1:0]            o_csr_rresp,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_empty,
`ifdef FIFO_CSR_IRQ_EN
  output logic                  o_csr_irq,
`endif
  output logic                  o_fifo_flush
);

  localparam int unsigned TimeoutW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned CntW     = (TimeoutW > 8) ? TimeoutW : 8;

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl     = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrFlushLen = ADDR_WIDTH'(2);
`ifdef FIFO_CSR_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] AddrIrqEn    = ADDR_WIDTH'(3);
`endif

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StIdle, StFlush, StDrain} state_e;

  state_e                r_state, w_state_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic                  r_full_meta, r_full_sync, r_empty_meta, r_empty_sync;
  logic                  r_flush;
  logic [7:0]            r_flush_len;
  logic                  r_full_seen, r_drain_to;
  logic                  r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic       w_wr_en, w_rd_en, w_wr_map, w_rd_map, w_busy;
  logic       w_flush_start, w_to_set, w_done_set;
  logic       w_status_wr, w_clr_full, w_clr_to;
  logic [7:0] w_wdata8, w_status, w_rd_byte;

`ifdef FIFO_CSR_IRQ_EN
  logic       r_done_pend, r_irq;
  logic [2:0] r_irq_en;
`endif

  assign o_csr_awready = r_awready;
  assign o_csr_wready  = r_awready;
  assign o_csr_bvalid  = r_bvalid;
  assign o_csr_bresp   = r_bresp;
  assign o_csr_arready = r_arready;
  assign o_csr_rvalid  = r_rvalid;
  assign o_csr_rdata   = r_rdata;
  assign o_csr_rresp   = r_rresp;
  assign o_fifo_flush  = r_flush;
`ifdef FIFO_CSR_IRQ_EN
  assign o_csr_irq     = r_irq;
`endif

  always_comb begin
    w_wr_en       = r_awready & i_csr_awvalid & i_csr_wvalid;
    w_rd_en       = r_arready & i_csr_arvalid;
    w_wdata8      = i_csr_wdata[7:0];
    w_busy        = (r_state != StIdle);
    w_flush_start = w_wr_en & (i_csr_awaddr == AddrCtrl) & w_wdata8[0] & ~w_busy;
    w_status_wr   = w_wr_en & (i_csr_awaddr == AddrStatus);
    w_clr_full    = w_status_wr & w_wdata8[3];
    w_clr_to      = w_status_wr & w_wdata8[4];
    w_wr_map      = (i_csr_awaddr == AddrCtrl) | (i_csr_awaddr == AddrStatus) |
`ifdef FIFO_CSR_IRQ_EN
                    (i_csr_awaddr == AddrIrqEn) |
`endif
                    (i_csr_awaddr == AddrFlushLen);
`ifdef FIFO_CSR_IRQ_EN
    w_status = {2'b00, r_done_pend, r_drain_to, r_full_seen, w_busy, r_full_sync, r_empty_sync};
`else
    w_status = {3'b000, r_drain_to, r_full_seen, w_busy, r_full_sync, r_empty_sync};
`endif
  end

  always_comb begin
    w_rd_byte = 8'h00;
    w_rd_map  = 1'b1;
    case (i_csr_araddr)
      AddrCtrl:     w_rd_byte = {7'd0, w_busy};
      AddrStatus:   w_rd_byte = w_status;
      AddrFlushLen: w_rd_byte = r_flush_len;
`ifdef FIFO_CSR_IRQ_EN
      AddrIrqEn:    w_rd_byte = {5'd0, r_irq_en};
`endif
      default:      w_rd_map  = 1'b0;
    endcase
  end

  // Counter is shared: flush length in StFlush, drain timeout budget in StDrain.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_set    = 1'b0;
    w_done_set  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_flush_start) begin
          w_state_nxt = StFlush;
          w_cnt_nxt   = CntW'(r_flush_len);
        end
      end
      StFlush: begin
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt = StDrain;
          w_cnt_nxt   = CntW'(DRAIN_TIMEOUT);
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      StDrain: begin
        if (r_empty_sync) begin
          w_state_nxt = StIdle;
          w_done_set  = 1'b1;
        end else if (r_cnt <= CntW'(1)) begin
          w_state_nxt = StIdle;
          w_to_set    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_csr_clk or negedge i_csr_resetn) begin
    if (!i_csr_resetn) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_full_meta  <= 1'b0;
      r_full_sync  <= 1'b0;
      r_empty_meta <= 1'b1;
      r_empty_sync <= 1'b1;
      r_flush      <= 1'b0;
      r_flush_len  <= 8'd4;
      r_full_seen  <= 1'b0;
      r_drain_to   <= 1'b0;
      r_awready    <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RespOkay;
      r_arready    <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rresp      <= RespOkay;
      r_rdata      <= '0;
    end else begin
      r_full_meta  <= i_fifo_full;
      r_full_sync  <= r_full_meta;
      r_empty_meta <= i_fifo_empty;
      r_empty_sync <= r_empty_meta;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush      <= (w_state_nxt == StFlush);
      // Set beats a same-cycle W1C.
      r_full_seen  <= r_full_sync | (r_full_seen & ~w_clr_full);
      r_drain_to   <= w_to_set | (r_drain_to & ~w_clr_to);
      if (w_wr_en && (i_csr_awaddr == AddrFlushLen)) begin
        r_flush_len <= (w_wdata8 == 8'd0) ? 8'd1 : w_wdata8;
      end
      r_awready <= i_csr_awvalid & i_csr_wvalid & ~r_bvalid & ~r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_map ? RespOkay : RespSlverr;
      end else if (r_bvalid && i_csr_bready) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= i_csr_arvalid & ~r_rvalid & ~r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= DATA_WIDTH'(w_rd_byte);
        r_rresp  <= w_rd_map ? RespOkay : RespSlverr;
      end else if (r_rvalid && i_csr_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

`ifdef FIFO_CSR_IRQ_EN
  always_ff @(posedge i_csr_clk or negedge i_csr_resetn) begin
    if (!i_csr_resetn) begin
      r_done_pend <= 1'b0;
      r_irq_en    <= 3'b000;
      r_irq       <= 1'b0;
    end else begin
      r_done_pend <= w_done_set | (r_done_pend & ~(w_status_wr & w_wdata8[5]));
      if (w_wr_en && (i_csr_awaddr == AddrIrqEn)) begin
        r_irq_en <= w_wdata8[2:0];
      end
      r_irq <= (r_done_pend & r_irq_en[0]) | (r_full_seen & r_irq_en[1]) |
               (r_drain_to & r_irq_en[2]);
    end
  end
`endif

endmodule
